// File: rtl/ahb_dec_pkg.sv
// Shared AHB-Lite types for the decoder/mux slice and its default slave.
package ahb_dec_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int NUM_SLV_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        ERR1,
        ERR2
    } def_state_e;

    // Data-phase select: slave index, or DSEL_DEF for the default slave
    typedef logic [3:0] dsel_t;
    localparam dsel_t DSEL_DEF = 4'd8;

    function automatic logic is_active(logic [1:0] t);
        return (t == HT_NONSEQ) || (t == HT_SEQ);
    endfunction

endpackage

// File: rtl/ahb_dec_mux_if.sv
// AHB-Lite bus bundle between the master, the decoder/mux and the slaves.
interface ahb_dec_mux_if #(
    parameter int NUM_SLV = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [ADDR_W-1:0]         haddr;
    logic [1:0]                htrans;
    logic [NUM_SLV-1:0]        hsel;
    logic [NUM_SLV*DATA_W-1:0] hrdata_s;
    logic [NUM_SLV-1:0]        hreadyout_s;
    logic [NUM_SLV-1:0]        hresp_s;
    logic [DATA_W-1:0]         hrdata;
    logic                      hready;
    logic                      hresp;

    modport slave (
        input  haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
        output hsel, hrdata, hready, hresp
    );

    modport master (
        output haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
        input  hsel, hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_default_slv.sv
// Default slave: two-cycle ERROR for unmapped transfers.
// AHB_DEC_ERRLOG_EN adds a sticky first-error address log.
module ahb_default_slv
    import ahb_dec_pkg::*;
`ifdef AHB_DEC_ERRLOG_EN
#(
    parameter int ADDR_W = 32
)
`endif
(
    input  logic              hclk,
    input  logic              hreset,
    input  logic              req,
`ifdef AHB_DEC_ERRLOG_EN
    input  logic [ADDR_W-1:0] haddr,
    input  logic              err_clr,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
`endif
    output logic              def_ready,
    output logic              def_resp
);

    def_state_e st, nxt;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) st <= IDLE;
        else        st <= nxt;
    end

    always_comb begin
        nxt       = st;
        def_ready = 1'b1;
        def_resp  = HRESP_OKAY;
        unique case (st)
            IDLE: if (req) nxt = ERR1;
            ERR1: begin
                nxt       = ERR2;
                def_ready = 1'b0;
                def_resp  = HRESP_ERROR;
            end
            ERR2: begin
                def_resp = HRESP_ERROR;
                nxt      = req ? ERR1 : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef AHB_DEC_ERRLOG_EN
    // req only fires on an ERR1 entry edge; a same-cycle clear loses to it
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (req && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_addr  <= haddr;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end
    end
`endif

endmodule

// File: rtl/ahb_dec_mux.sv
// AHB-Lite address decoder plus registered data-phase response mux.
// AHB_DEC_ERRLOG_EN adds err_clr/err_valid/err_addr.
module ahb_dec_mux
    import ahb_dec_pkg::*;
#(
    parameter int NUM_SLV = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MATCH_W = 8,
    parameter logic [NUM_SLV*MATCH_W-1:0] SLV_BASE = {8'hB0, 8'hA0}
) (
    input  logic              hclk,
    input  logic              hreset,
`ifdef AHB_DEC_ERRLOG_EN
    input  logic              err_clr,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
`endif
    ahb_dec_mux_if.slave      bus
);

    if (NUM_SLV < 1 || NUM_SLV > NUM_SLV_MAX) begin : g_bad_cfg
        $fatal(1, "ahb_dec_mux: NUM_SLV out of range 1..8");
    end

    logic [MATCH_W-1:0] field;
    logic [NUM_SLV-1:0] hsel;
    dsel_t              hit;
    logic               found;
    dsel_t              dsel;
    logic               rdy;
    logic               req;
    logic               def_ready;
    logic               def_resp;

    assign field = bus.haddr[ADDR_W-1 -: MATCH_W];

    // Lowest index wins on overlapping bases
    always_comb begin
        hsel  = '0;
        hit   = DSEL_DEF;
        found = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!found && field == SLV_BASE[i*MATCH_W +: MATCH_W]) begin
                hsel[i] = 1'b1;
                hit     = dsel_t'(i);
                found   = 1'b1;
            end
        end
    end

    assign bus.hsel = hsel;
    assign req      = rdy && !found && is_active(bus.htrans);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)   dsel <= DSEL_DEF;
        else if (rdy) dsel <= hit;
    end

    always_comb begin
        bus.hrdata = '0;
        rdy        = def_ready;
        bus.hresp  = def_resp;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (dsel == dsel_t'(i)) begin
                bus.hrdata = bus.hrdata_s[i*DATA_W +: DATA_W];
                rdy        = bus.hreadyout_s[i];
                bus.hresp  = bus.hresp_s[i];
            end
        end
    end

    assign bus.hready = rdy;

    ahb_default_slv
`ifdef AHB_DEC_ERRLOG_EN
    #(.ADDR_W(ADDR_W))
`endif
    u_def (
        .hclk      (hclk),
        .hreset    (hreset),
        .req       (req),
`ifdef AHB_DEC_ERRLOG_EN
        .haddr     (bus.haddr),
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
`endif
        .def_ready (def_ready),
        .def_resp  (def_resp)
    );

endmodule

// File: tb/tb_ahb_dec_mux.sv
// Directed table-driven bench for ahb_dec_mux.
module tb_ahb_dec_mux;

    logic hclk;
    logic hreset;
`ifdef AHB_DEC_ERRLOG_EN
    logic        err_clr;
    logic        err_valid;
    logic [31:0] err_addr;
`endif

    ahb_dec_mux_if #(.NUM_SLV(2), .ADDR_W(32), .DATA_W(32)) bus ();

    ahb_dec_mux dut (
        .hclk      (hclk),
        .hreset    (hreset),
`ifdef AHB_DEC_ERRLOG_EN
        .err_clr   (err_clr),
        .err_valid (err_valid),
        .err_addr  (err_addr),
`endif
        .bus       (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  tr;
        logic [1:0]  rdy;
        logic [1:0]  rsp;
        logic [1:0]  hsel;
        logic        hready;
        logic        hresp;
        logic [31:0] rdata;
    } vec_t;

    vec_t v[20];

    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [1:0] t,
                         input logic [1:0] r, input logic [1:0] s);
        bus.haddr       = a;
        bus.htrans      = t;
        bus.hreadyout_s = r;
        bus.hresp_s     = s;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
`ifdef AHB_DEC_ERRLOG_EN
        err_clr = 1'b0;
`endif
        // address, htrans, hreadyout_s, hresp_s | hsel, hready, hresp, hrdata
        v[0]  = '{32'hA000_0000, 2'd0, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 32'h0};
        v[1]  = '{32'hB000_0010, 2'd2, 2'b11, 2'b00, 2'b10, 1'b1, 1'b0, D0};
        v[2]  = '{32'hB000_0010, 2'd0, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, D1};
        v[3]  = '{32'hB000_0010, 2'd0, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, D1};
        v[4]  = '{32'hC000_0000, 2'd2, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, D1};
        v[5]  = '{32'h0000_0000, 2'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0};
        v[6]  = '{32'h0000_0000, 2'd0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0};
        v[7]  = '{32'hC000_0000, 2'd0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0};
        v[8]  = '{32'hC000_0000, 2'd1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0};
        v[9]  = '{32'h8000_0000, 2'd2, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0};
        v[10] = '{32'hA000_0004, 2'd2, 2'b11, 2'b00, 2'b01, 1'b0, 1'b1, 32'h0};
        v[11] = '{32'hA000_0004, 2'd2, 2'b11, 2'b00, 2'b01, 1'b1, 1'b1, 32'h0};
        v[12] = '{32'h0000_0000, 2'd0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b1, D0};
        v[13] = '{32'h0000_0000, 2'd0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, D0};
        v[14] = '{32'hC000_0000, 2'd2, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0};
        v[15] = '{32'hD000_0000, 2'd3, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0};
        v[16] = '{32'hD000_0000, 2'd3, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0};
        v[17] = '{32'h0000_0000, 2'd0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0};
        v[18] = '{32'h0000_0000, 2'd0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 32'h0};
        v[19] = '{32'h0000_0000, 2'd0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0};

        // Reset with random inputs
        hreset       = 1'b1;
        bus.haddr    = $urandom;
        bus.htrans   = 2'($urandom_range(0, 3));
        bus.hrdata_s = {$urandom, $urandom};
        bus.hreadyout_s = 2'($urandom_range(0, 3));
        bus.hresp_s     = 2'($urandom_range(0, 3));
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        chk("rst_hready", 32'(bus.hready), 32'd1);
        chk("rst_hresp", 32'(bus.hresp), 32'd0);
        chk("rst_hrdata", bus.hrdata, 32'h0);
`ifdef AHB_DEC_ERRLOG_EN
        chk("rst_err_valid", 32'(err_valid), 32'd0);
        chk("rst_err_addr", err_addr, 32'h0);
`endif
        step();
        hreset       = 1'b0;
        bus.hrdata_s = {D1, D0};
        drive(32'hA000_0000, 2'd0, 2'b11, 2'b00);
        #1;
        chk("rel_hsel", 32'(bus.hsel), 32'h1);

        for (int i = 0; i < 20; i++) begin
            drive(v[i].addr, v[i].tr, v[i].rdy, v[i].rsp);
            @(negedge hclk);
            chk($sformatf("v%0d_hsel", i), 32'(bus.hsel), 32'(v[i].hsel));
            chk($sformatf("v%0d_hready", i), 32'(bus.hready), 32'(v[i].hready));
            chk($sformatf("v%0d_hresp", i), 32'(bus.hresp), 32'(v[i].hresp));
            chk($sformatf("v%0d_hrdata", i), bus.hrdata, v[i].rdata);
            step();
        end

`ifdef AHB_DEC_ERRLOG_EN
        // First error (0xC0000000) held despite later unmapped transfers
        chk("log_valid", 32'(err_valid), 32'd1);
        chk("log_addr", err_addr, 32'hC000_0000);
        drive(32'hE000_0000, 2'd2, 2'b11, 2'b00);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drive(32'h0, 2'd0, 2'b11, 2'b00);
        chk("clr_new_valid", 32'(err_valid), 32'd1);
        chk("clr_new_addr", err_addr, 32'hE000_0000);
        repeat (2) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_valid", 32'(err_valid), 32'd0);
        chk("clr_addr", err_addr, 32'h0);
`endif

        // Reset during ERR1 aborts the error response at once
        drive(32'hF000_0000, 2'd2, 2'b11, 2'b00);
        step();
        drive(32'h0, 2'd0, 2'b11, 2'b00);
        @(negedge hclk);
        chk("err1_hready", 32'(bus.hready), 32'd0);
        chk("err1_hresp", 32'(bus.hresp), 32'd1);
        #1;
        hreset = 1'b1;
        #1;
        chk("arst_hready", 32'(bus.hready), 32'd1);
        chk("arst_hresp", 32'(bus.hresp), 32'd0);
        chk("arst_hrdata", bus.hrdata, 32'h0);
        step();
        hreset = 1'b0;
        @(negedge hclk);
        chk("post_hready", 32'(bus.hready), 32'd1);
        chk("post_hresp", 32'(bus.hresp), 32'd0);
        step();
        @(negedge hclk);
        chk("post2_hready", 32'(bus.hready), 32'd1);
        chk("post2_hresp", 32'(bus.hresp), 32'd0);
`ifdef AHB_DEC_ERRLOG_EN
        chk("post_err_valid", 32'(err_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
